// File: rtl/mld_7_4_pkg.sv
// Shared constants for the (7,4) cyclic-code encoder/decoder pair, g(x) = 1 + x + x^3.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mld_7_4_pkg;

    localparam int N = 7;   // codeword length
    localparam int K = 4;   // message length
    localparam int R = 3;   // parity length, degree of g(x)

    // Coefficients of g(x), bit i = coefficient of x^i: x^3 + x + 1.
    localparam logic [3:0] GEN_POLY = 4'b1011;

    // Encoder sequencing states; the decoder's bench uses the same encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Parity register operating modes.
    localparam logic LFSR_DIVIDE = 1'b0;   // absorb a message bit, divide by g(x)
    localparam logic LFSR_UNLOAD = 1'b1;   // shift the remainder out, high-order first

endpackage

// File: rtl/mld_7_4_parity_lfsr.sv
// Divide-by-g(x) parity register: absorbs message bits high-order first, then unloads the remainder.
// Latency: out_bit is the registered top stage; each enabled cycle advances one bit.
// Backpressure: none; the caller sequences en/mode, clear wins over en.
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   clear            zero the register (used at each accepted message)
//   en               advance one step this cycle
//   shift_in         message bit entering the divider (DIVIDE mode only)
//   mode             LFSR_DIVIDE / LFSR_UNLOAD
//   out_bit          current top stage r2
module mld_7_4_parity_lfsr
    import mld_7_4_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    input  logic shift_in,
    input  logic mode,
    output logic out_bit
);

    logic [R-1:0] r_q;
    logic [R-1:0] r_d;
    logic         fb;

    // Premultiplying by x^R is implicit: the message enters at the top
    // stage, so after K steps the register holds x^3*m(x) mod g(x).
    always_comb begin
        r_d = r_q;
        fb  = shift_in ^ r_q[R-1];
        if (clear) begin
            r_d = '0;
        end else if (en) begin
            if (mode == LFSR_DIVIDE) begin
                r_d[0] = fb & GEN_POLY[0];
                for (int i = 1; i < R; i++) begin
                    r_d[i] = r_q[i-1] ^ (fb & GEN_POLY[i]);
                end
            end else begin
                r_d = {r_q[R-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

    assign out_bit = r_q[R-1];

endmodule

// File: rtl/mld_7_4_serial_encoder.sv
// Systematic (7,4) cyclic encoder: takes a 4-bit message, emits v6..v0 serially with optional error injection.
// Latency: handshake at edge k -> load/serial_bit valid from edge k+1 to k+8, then GAP_CYCLES idle-load cycles.
// Backpressure: msg_ready only in IDLE (never during reset); msg_valid while busy is ignored.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   msg_valid             msg_data / error_mask valid
//   msg_data[0:3]         message, msg_data[i] = m_i
//   error_mask[0:6]       bit i flips codeword bit v_i, captured at the handshake
//   msg_ready             encoder accepts a message this cycle
//   load                  high for exactly 7 cycles per codeword, qualifies serial_bit
//   serial_bit            codeword bit, v6 first
//   busy                  high while sending or in the post-codeword gap
module mld_7_4_serial_encoder
    import mld_7_4_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 7   // legal range 0..15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       msg_valid,
    input  logic [0:3] msg_data,
    input  logic [0:6] error_mask,
    output logic       msg_ready,
    output logic       load,
    output logic       serial_bit,
    output logic       busy
);

    localparam logic [3:0] GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;
    logic [0:3] msg_q;
    logic [0:6] mask_q;
    logic       load_q, load_d;
    logic       serial_q, serial_d;

    logic       accept;
    logic       last_bit;
    logic       gap_done;
    logic [1:0] midx;       // message bit sent at this count: m3..m0
    logic [2:0] vidx;       // codeword bit sent at this count: v6..v0
    logic       lfsr_en;
    logic       lfsr_mode;
    logic       lfsr_in;
    logic       lfsr_out;

    assign msg_ready = !reset && (state_q == IDLE);
    assign accept    = msg_valid && msg_ready;
    assign last_bit  = (bit_cnt_q == 3'(N - 1));
    assign gap_done  = (gap_cnt_q == GAP_LAST);
    assign midx      = 2'd3 - bit_cnt_q[1:0];
    assign vidx      = 3'd6 - bit_cnt_q;

    // State and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // Next state.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = SEND;
                    bit_cnt_d = '0;
                end
            end
            SEND: begin
                if (last_bit) begin
                    bit_cnt_d = '0;
                    gap_cnt_d = '0;
                    state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
                end else begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            GAP: begin
                if (gap_done) begin
                    gap_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: the first K counts pass message bits straight through while
    // the divider absorbs them; the last R counts unload the remainder.
    always_comb begin
        load_d    = 1'b0;
        serial_d  = 1'b0;
        lfsr_en   = 1'b0;
        lfsr_mode = LFSR_DIVIDE;
        lfsr_in   = 1'b0;
        if (state_q == SEND) begin
            load_d  = 1'b1;
            lfsr_en = 1'b1;
            if (bit_cnt_q < 3'(K)) begin
                lfsr_in  = msg_q[midx];
                serial_d = msg_q[midx] ^ mask_q[vidx];
            end else begin
                lfsr_mode = LFSR_UNLOAD;
                serial_d  = lfsr_out ^ mask_q[vidx];
            end
        end
    end

    // Message and mask are frozen for the whole codeword.
    always_ff @(posedge clk) begin
        if (reset) begin
            msg_q  <= '0;
            mask_q <= '0;
        end else if (accept) begin
            msg_q  <= msg_data;
            mask_q <= error_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            load_q   <= 1'b0;
            serial_q <= 1'b0;
        end else begin
            load_q   <= load_d;
            serial_q <= serial_d;
        end
    end

    mld_7_4_parity_lfsr u_parity (
        .clk      (clk),
        .reset    (reset),
        .clear    (accept),
        .en       (lfsr_en),
        .shift_in (lfsr_in),
        .mode     (lfsr_mode),
        .out_bit  (lfsr_out)
    );

    assign load       = load_q;
    assign serial_bit = serial_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mld_7_4_serial_encoder.sv
module tb_mld_7_4_serial_encoder;

    localparam int GAP_A  = 7;
    localparam int GAP_B  = 0;
    localparam int IDLE_S = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       vld [2];
    logic [0:3] dat [2];
    logic [0:6] msk [2];
    logic       rdy_a, load_a, ser_a, busy_a;
    logic       rdy_b, load_b, ser_b, busy_b;

    mld_7_4_serial_encoder #(.GAP_CYCLES(GAP_A)) dut_a (
        .clk(clk), .reset(reset), .msg_valid(vld[0]), .msg_data(dat[0]),
        .error_mask(msk[0]), .msg_ready(rdy_a), .load(load_a),
        .serial_bit(ser_a), .busy(busy_a)
    );

    mld_7_4_serial_encoder #(.GAP_CYCLES(GAP_B)) dut_b (
        .clk(clk), .reset(reset), .msg_valid(vld[1]), .msg_data(dat[1]),
        .error_mask(msk[1]), .msg_ready(rdy_b), .load(load_b),
        .serial_bit(ser_b), .busy(busy_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: per instance, the number of edges since the accepting edge and
    // the 7-bit transmitted stream (bit 6 goes out first).
    int         since [2]     = '{IDLE_S, IDLE_S};
    logic [6:0] exp_s [2]     = '{7'd0, 7'd0};
    logic       hs [2]        = '{1'b0, 1'b0};
    logic       started       = 1'b0;
    logic       rst_seen      = 1'b0;

    logic [6:0] obs [2]       = '{7'd0, 7'd0};
    logic       prev_load [2] = '{1'b0, 1'b0};
    int         rises_a[$];
    int         low_run_b     = 0;
    int         last_low_b    = -1;
    int         rise_cnt_b    = 0;

    function automatic int gap_of(input int i);
        return (i == 0) ? GAP_A : GAP_B;
    endfunction

    // Systematic codeword by polynomial long division, XORed with the mask.
    function automatic logic [6:0] stream_of(input logic [0:3] m, input logic [0:6] e);
        int         mv;
        int         rem;
        int         v;
        logic [6:0] s;
        mv = 0;
        for (int i = 0; i < 4; i++) if (m[i]) mv += (1 << i);
        rem = mv << 3;
        for (int b = 6; b >= 3; b--) if (rem[b]) rem ^= (32'b1011 << (b - 3));
        v = (mv << 3) | rem;
        for (int j = 0; j < 7; j++) s[j] = v[j] ^ e[j];
        return s;
    endfunction

    task automatic chk1(input string name, input int inst, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d cyc=%0d got=%b want=%b", name, inst, cyc, act, exp);
        end
    endtask

    task automatic chk7(input string name, input int inst, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d cyc=%0d got=%b want=%b", name, inst, cyc, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    // Reference model, advanced on every edge from the inputs as driven.
    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                since[i] = IDLE_S;
                hs[i]    = 1'b0;
            end else if (vld[i] && since[i] > 6 + gap_of(i)) begin
                exp_s[i] = stream_of(dat[i], msk[i]);
                since[i] = 0;
                hs[i]    = 1'b1;
            end else begin
                hs[i] = 1'b0;
                if (since[i] < IDLE_S) since[i]++;
            end
        end
        rst_seen = reset;
        if (reset) started = 1'b1;
    end

    // Compare on the falling edge, every cycle after the first reset.
    always @(negedge clk) begin : cmp
        logic ar, al, as, ab, eb, er, el;
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                ar = (i == 0) ? rdy_a  : rdy_b;
                al = (i == 0) ? load_a : load_b;
                as = (i == 0) ? ser_a  : ser_b;
                ab = (i == 0) ? busy_a : busy_b;
                eb = (since[i] <= 6 + gap_of(i));
                er = !reset && !eb;
                el = (since[i] >= 1) && (since[i] <= 7);
                chk1("msg_ready", i, ar, er);
                chk1("busy", i, ab, eb);
                chk1("load", i, al, el);
                if (el) chk1("serial_bit", i, as, exp_s[i][7 - since[i]]);
                if (rst_seen) chk1("serial_rst", i, as, 1'b0);
                if (al) obs[i] = {obs[i][5:0], as};
                if (al && !prev_load[i]) begin
                    if (i == 0) begin
                        rises_a.push_back(cyc);
                    end else begin
                        if (rise_cnt_b > 0) last_low_b = low_run_b;
                        rise_cnt_b++;
                    end
                end
                if (i == 1) low_run_b = al ? 0 : low_run_b + 1;
                prev_load[i] = al;
            end
        end
    end

    task automatic wait_accept(input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!hs[0] && n < 60);
        chk1(name, 0, hs[0], 1'b1);
    endtask

    task automatic send_dir(input logic [0:3] m, input logic [0:6] e,
                            input logic [6:0] want, input string name);
        @(posedge clk); #1;
        vld[0] = 1'b1;
        dat[0] = m;
        msk[0] = e;
        wait_accept({name, "_accept"});
        vld[0] = 1'b0;
        msk[0] = 7'b1111111;   // must not affect the codeword in flight
        repeat (7) @(posedge clk);
        @(negedge clk); #1;
        chk7(name, 0, obs[0], want);
    endtask

    initial begin
        reset = 1'b1;
        vld   = '{1'b0, 1'b0};
        dat   = '{4'd0, 4'd0};
        msk   = '{7'd0, 7'd0};

        // Hand-computed codewords pin the model.
        chk7("pin_zero", 0, stream_of(4'b0000, 7'b0000000), 7'b0000000);
        chk7("pin_m0",   0, stream_of(4'b1000, 7'b0000000), 7'b0001011);
        chk7("pin_m3",   0, stream_of(4'b0001, 7'b0000000), 7'b1000101);
        chk7("pin_ones", 0, stream_of(4'b1111, 7'b0000000), 7'b1111111);
        chk7("pin_e5",   0, stream_of(4'b1111, 7'b0000010), 7'b1011111);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        send_dir(4'b0000, 7'b0000000, 7'b0000000, "cw_zero");
        send_dir(4'b1000, 7'b0000000, 7'b0001011, "cw_m0");
        send_dir(4'b0001, 7'b0000000, 7'b1000101, "cw_m3");
        send_dir(4'b1111, 7'b0000000, 7'b1111111, "cw_ones");
        send_dir(4'b1111, 7'b0000010, 7'b1011111, "cw_err_v5");

        // Back-to-back with valid held high on both builds.
        @(posedge clk); #1;
        rises_a.delete();
        rise_cnt_b = 0;
        last_low_b = -1;
        vld[0] = 1'b1; dat[0] = 4'b1010; msk[0] = 7'd0;
        vld[1] = 1'b1; dat[1] = 4'b0110; msk[1] = 7'd0;
        repeat (40) @(posedge clk);
        #1 vld[0] = 1'b0; vld[1] = 1'b0;
        chk1("b2b_two_loads", 0, rises_a.size() >= 2, 1'b1);
        if (rises_a.size() >= 2) chki("b2b_spacing", rises_a[1] - rises_a[0], 15);
        chki("gap0_low_run", last_low_b, 1);
        repeat (20) @(posedge clk);

        // Reset during SEND count 3.
        #1;
        vld[0] = 1'b1; dat[0] = 4'b1101; msk[0] = 7'd0;
        wait_accept("rst_mid_accept");
        vld[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk1("rst_mid_load", 0, load_a, 1'b0);
        reset = 1'b0;
        @(negedge clk); #1;
        chk1("rst_mid_ready", 0, rdy_a, 1'b1);
        send_dir(4'b1000, 7'b0000000, 7'b0001011, "cw_after_reset");

        // Randomized traffic, source holds each message until accepted.
        repeat (3000) begin
            @(posedge clk); #1;
            reset = ($urandom_range(0, 399) == 0);
            for (int i = 0; i < 2; i++) begin
                if (hs[i] || !vld[i]) begin
                    vld[i] = ($urandom_range(0, 2) != 0);
                    dat[i] = 4'($urandom);
                    msk[i] = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'd0;
                end
            end
        end
        @(posedge clk); #1;
        reset  = 1'b0;
        vld[0] = 1'b0;
        vld[1] = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
